// File: rtl/fir_mul_share_arbiter_pkg.sv
// Shared types and widths for the FIR multiplier-sharing arbiter.
package fir_mul_pkg;

   localparam int A_W         = 16;
   localparam int B_W         = 12;
   localparam int P_W         = A_W + B_W;
   localparam int NUM_REQ_DEF = 4;
   localparam int ID_W        = $clog2(NUM_REQ_DEF);

   typedef struct packed {
      logic signed [A_W-1:0] a;
      logic signed [B_W-1:0] b;
   } mul_req_t;

   typedef struct packed {
      logic [ID_W-1:0]       id;
      logic signed [P_W-1:0] p;
   } mul_rsp_t;

endpackage

// File: rtl/fir_mul_share_arbiter_if.sv
// Request/response bundle between FIR requesters and the shared multiplier.
interface fir_mul_share_arbiter_if
   import fir_mul_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
);
   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ-1:0]     req_ready;
   logic [NUM_REQ*A_W-1:0] req_a;
   logic [NUM_REQ*B_W-1:0] req_b;
   logic [NUM_REQ-1:0]     rsp_valid;
   logic [NUM_REQ-1:0]     rsp_ready;
   logic [P_W-1:0]         rsp_p;
   logic [IDW-1:0]         rsp_id;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_p, rsp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_p, rsp_id
   );

endinterface

// File: rtl/fir_mul_share_arbiter_mul.sv
// Combinational full-precision signed multiply; operands sign-extended to P_W.
module fir_shared_mul
   import fir_mul_pkg::*;
#(
   parameter int AW = A_W,
   parameter int BW = B_W,
   parameter int PW = P_W
) (
   input  logic signed [AW-1:0] a,
   input  logic signed [BW-1:0] b,
   output logic signed [PW-1:0] p
);

   assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/fir_mul_share_arbiter.sv
// Round-robin arbiter sharing one registered signed multiplier among NUM_REQ requesters.
module fir_mul_share_arbiter
   import fir_mul_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   fir_mul_share_arbiter_if.slave bus
);

   localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [IDW-1:0]        ptr, gnt_id, cand, s1_id;
   logic                  gnt_found, can_accept, accept, s1_valid;
   logic signed [P_W-1:0] s1_p, prod;
   logic [NUM_REQ-1:0]    ready_vec, rsp_vec;
   mul_req_t              sel;
   mul_req_t              ops [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_ops
      assign ops[i].a = bus.req_a[i*A_W +: A_W];
      assign ops[i].b = bus.req_b[i*B_W +: B_W];
   end

   // First valid index strictly after the last winner, wrapping.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDW'((int'(ptr) + k) % NUM_REQ);
         if (!gnt_found && bus.req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_id    = cand;
         end
      end
   end

   assign can_accept = !s1_valid || bus.rsp_ready[s1_id];
   assign accept     = gnt_found && can_accept && !ap_rst;
   assign sel        = ops[gnt_id];

   fir_shared_mul #(.AW(A_W), .BW(B_W), .PW(P_W)) u_mul (
      .a (sel.a),
      .b (sel.b),
      .p (prod)
   );

   always_comb begin
      ready_vec = '0;
      rsp_vec   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         ready_vec[i] = accept && (gnt_id == IDW'(i));
         rsp_vec[i]   = s1_valid && (s1_id == IDW'(i));
      end
   end

   assign bus.req_ready = ready_vec;
   assign bus.rsp_valid = rsp_vec;
   assign bus.rsp_p     = s1_p;
   assign bus.rsp_id    = s1_id;

   // Accept takes priority over drain so a product can be replaced every cycle.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         s1_valid <= 1'b0;
         s1_id    <= '0;
         s1_p     <= '0;
         ptr      <= IDW'(NUM_REQ - 1);
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_id    <= gnt_id;
         s1_p     <= prod;
         ptr      <= gnt_id;
      end else if (s1_valid && bus.rsp_ready[s1_id]) begin
         s1_valid <= 1'b0;
      end
   end

endmodule
